// File: rtl/wb_uart_lite_pkg.sv
// Shared register offsets, STATUS bit positions and FSM encodings for wb_uart_lite.
package wb_uart_lite_pkg;

    // Register select values, taken from wb_adr_i[3:2]
    localparam logic [1:0] RegData     = 2'd0;
    localparam logic [1:0] RegStatus   = 2'd1;
    localparam logic [1:0] RegDivisor  = 2'd2;
    localparam logic [1:0] RegUnmapped = 2'd3;

    localparam int unsigned StTxBusy     = 0;
    localparam int unsigned StRxValid    = 1;
    localparam int unsigned StRxOverrun  = 2;
    localparam int unsigned StRxFrameErr = 3;

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO for received bytes; a push into a full FIFO is accepted when a pop
// happens in the same cycle. Depth must be a power of two.
module uart_rx_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             nrst_i,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned Aw = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [Aw-1:0]    wptr_q, rptr_q;
    logic [Aw:0]      count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (Aw+1)'(Depth));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rptr_q];

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/wb_uart_lite.sv
// Wishbone-attached 8N1 UART with programmable divisor. Define WB_UART_LITE_RX_FIFO_EN to
// replace the single RX holding register with an RX_DEPTH-entry FIFO.
module wb_uart_lite
    import wb_uart_lite_pkg::*;
#(
    parameter int unsigned DEFAULT_DIV = 433,
    parameter int unsigned RX_DEPTH    = 4
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq_o
);

    logic        ack_q, err_q;
    logic [31:0] dat_q, rd_value;
    logic [15:0] divisor_q;
    logic        overrun_q, frame_err_q;
    logic        wb_req, reg_access;
    logic [1:0]  reg_sel;
    logic        wr_data, rd_data, wr_status, wr_div;
    logic        rx_valid, rx_blocked, rx_pop;
    logic [7:0]  rx_head;

    logic unused_inputs;
    assign unused_inputs = ^{wb_cti_i, wb_bte_i, wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:2]};

    // A request is only sampled while no response is pending, so ack/err are single pulses.
    assign wb_req     = wb_cyc_i && wb_stb_i && !ack_q && !err_q;
    assign reg_sel    = wb_adr_i[3:2];
    assign reg_access = wb_req && (reg_sel != RegUnmapped);
    assign wr_data    = reg_access && wb_we_i && (reg_sel == RegData) && wb_sel_i[0];
    assign rd_data    = reg_access && !wb_we_i && (reg_sel == RegData);
    assign wr_status  = reg_access && wb_we_i && (reg_sel == RegStatus) && wb_sel_i[0];
    assign wr_div     = reg_access && wb_we_i && (reg_sel == RegDivisor);
    assign rx_pop     = rd_data && rx_valid;

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_dat_o = dat_q;
    assign irq_o    = rx_valid;

    // ---------------- TX ----------------
    tx_state_e  tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_line_q, tx_line_d;
    logic        tx_busy, tx_done;

    assign tx_busy = (tx_state_q != TxIdle);
    assign tx_done = (tx_cnt_q == tx_div_q);
    assign uart_tx = tx_line_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_done ? 16'd0 : tx_cnt_q + 16'd1;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        unique case (tx_state_q)
            TxIdle: begin
                tx_cnt_d = '0;
                if (wr_data) begin
                    tx_state_d = TxStart;
                    tx_shift_d = wb_dat_i[7:0];
                    tx_div_d   = divisor_q;
                    tx_bit_d   = '0;
                end
            end
            TxStart: if (tx_done) tx_state_d = TxData;
            TxData: begin
                if (tx_done) begin
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) tx_state_d = TxStop;
                    else                  tx_bit_d   = tx_bit_q + 3'd1;
                end
            end
            TxStop: if (tx_done) tx_state_d = TxIdle;
            default: tx_state_d = TxIdle;
        endcase

        unique case (tx_state_d)
            TxStart: tx_line_d = 1'b0;
            TxData:  tx_line_d = tx_shift_d[0];
            default: tx_line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_div_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
        end
    end

    // ---------------- RX ----------------
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    logic        rx_fall, rx_done, rx_push, rx_stop_bad;

    assign rx_fall     = rx_prev_q && !rx_sync_q;
    assign rx_done     = (rx_cnt_q == rx_div_q);
    assign rx_push     = (rx_state_q == RxStop) && rx_done && rx_sync_q;
    assign rx_stop_bad = (rx_state_q == RxStop) && rx_done && !rx_sync_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 16'd1;
        rx_div_d   = rx_div_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        unique case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = '0;
                if (rx_fall) begin
                    rx_state_d = RxStart;
                    rx_div_d   = divisor_q;
                end
            end
            RxStart: begin
                // Half a bit in: a line already back high was only a glitch.
                if (rx_cnt_q == (rx_div_q >> 1)) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (rx_done) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RxStop;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end
            end
            RxStop: begin
                if (rx_done) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RxIdle;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_div_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_meta_q  <= uart_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // ---------------- RX storage ----------------
`ifdef WB_UART_LITE_RX_FIFO_EN
    logic fifo_full, fifo_empty;

    uart_rx_fifo #(
        .Depth (RX_DEPTH),
        .Width (8)
    ) u_rx_fifo (
        .clk_i  (clk_i),
        .nrst_i (nrst_i),
        .push   (rx_push),
        .wdata  (rx_shift_q),
        .pop    (rx_pop),
        .rdata  (rx_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign rx_valid   = !fifo_empty;
    assign rx_blocked = fifo_full && !rx_pop;
`else
    localparam int unsigned UnusedRxDepth = RX_DEPTH;
    logic       hold_valid_q;
    logic [7:0] hold_data_q;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else if (rx_push && !rx_blocked) begin
            hold_valid_q <= 1'b1;
            hold_data_q  <= rx_shift_q;
        end else if (rx_pop) begin
            hold_valid_q <= 1'b0;
        end
    end

    assign rx_valid   = hold_valid_q;
    assign rx_head    = hold_data_q;
    assign rx_blocked = hold_valid_q && !rx_pop;
`endif

    // ---------------- Register file ----------------
    always_comb begin
        rd_value = '0;
        case (reg_sel)
            RegData:    if (rx_valid) rd_value[7:0] = rx_head;
            RegStatus: begin
                rd_value[StTxBusy]     = tx_busy;
                rd_value[StRxValid]    = rx_valid;
                rd_value[StRxOverrun]  = overrun_q;
                rd_value[StRxFrameErr] = frame_err_q;
            end
            RegDivisor: rd_value[15:0] = divisor_q;
            default:    rd_value = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            dat_q       <= '0;
            divisor_q   <= 16'(DEFAULT_DIV);
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            ack_q <= reg_access;
            err_q <= wb_req && (reg_sel == RegUnmapped);
            dat_q <= (reg_access && !wb_we_i) ? rd_value : 32'd0;
            if (wr_div && wb_sel_i[0]) divisor_q[7:0]  <= wb_dat_i[7:0];
            if (wr_div && wb_sel_i[1]) divisor_q[15:8] <= wb_dat_i[15:8];
            // New events win over a simultaneous write-1-to-clear.
            if (rx_push && rx_blocked)                    overrun_q <= 1'b1;
            else if (wr_status && wb_dat_i[StRxOverrun])  overrun_q <= 1'b0;
            if (rx_stop_bad)                              frame_err_q <= 1'b1;
            else if (wr_status && wb_dat_i[StRxFrameErr]) frame_err_q <= 1'b0;
        end
    end

endmodule

// File: doc/wb_uart_lite.md
WB_UART_LITE -- requirements
Module: wb_uart_lite

Interface
REQ-001 Parameter DEFAULT_DIV, default 433, reset value of DIVISOR (bit period = DIVISOR+1 clocks).
REQ-002 Parameter RX_DEPTH, default 4, RX FIFO depth (power of 2, used only when WB_UART_LITE_RX_FIFO_EN is defined).
REQ-003 clk_i  input  1  system clock; one clock domain only.
REQ-004 nrst_i  input  1  reset, asynchronous assert, active-low.
REQ-005 wb_adr_i  input  4  byte address; bits [3:2] select register.
REQ-006 wb_dat_i  input  32  write data; wb_sel_i  input  4  byte lanes; wb_we_i  input  1  write enable.
REQ-007 wb_cyc_i, wb_stb_i  input  1 each  Wishbone cycle/strobe.
REQ-008 wb_cti_i  input  3, wb_bte_i  input  2  accepted, ignored (classic cycles only).
REQ-009 wb_dat_o  output  32  read data; wb_ack_o  output  1  ack; wb_err_o  output  1  error.
REQ-010 uart_rx  input  1  serial in, asynchronous; uart_tx  output  1  serial out, idle high.
REQ-011 irq_o  output  1  high while RX data is available.

Function
REQ-012 Register map: 0x0 DATA (W: TX byte [7:0]; R: RX byte [7:0], pops), 0x4 STATUS (R: [0] tx_busy, [1] rx_valid, [2] rx_overrun, [3] rx_frame_err; W1C on [3:2]), 0x8 DIVISOR [15:0] R/W, 0xC unmapped.
REQ-013 wb_ack_o SHALL pulse exactly one cycle, registered, on the cycle after cyc&stb is sampled high with ack low; no back-to-back ack without a fresh strobe sample.
REQ-014 Access to 0xC SHALL assert wb_err_o instead of wb_ack_o, same timing; no state change.
REQ-015 Byte writes honour wb_sel_i; DATA write requires wb_sel_i[0].
REQ-016 TX FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE; each state held DIVISOR+1 clocks; 8N1 framing.
REQ-017 DATA write in IDLE launches frame; tx_busy high from next cycle until STOP ends.
REQ-018 DATA write while tx_busy SHALL be acked and discarded.
REQ-019 uart_rx SHALL pass through a 2-flop synchronizer before use.
REQ-020 RX FSM: IDLE -> START on falling edge; at half bit period, line high returns to IDLE (glitch reject), low enters DATA; sample each bit at mid-period; STOP sampled once.
REQ-021 STOP sampled low: set rx_frame_err, discard byte, return IDLE.
REQ-022 Valid byte with storage full: set rx_overrun, discard new byte, keep stored data.
REQ-023 DATA read with rx_valid low returns 0x00, no side effect; upper read bits always 0.
REQ-024 DIVISOR write takes effect at next frame start; in-flight frames keep old period.
REQ-025 Simultaneous RX push and DATA pop in same cycle SHALL both succeed; no overrun.

Reset
REQ-026 nrst_i low: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, uart_tx=1, irq_o=0, both FSMs IDLE, storage empty, all flags 0, DIVISOR=DEFAULT_DIV.
REQ-027 Reset mid-frame aborts TX/RX immediately; uart_tx high within the asserting edge.

Configuration
REQ-028 WB_UART_LITE_RX_FIFO_EN defined: RX storage is RX_DEPTH-entry FIFO; rx_valid = not empty; overrun only when full.
REQ-029 WB_UART_LITE_RX_FIFO_EN undefined: single holding register; overrun when rx_valid already set.

Structure
REQ-030 Package wb_uart_lite_pkg holds register offsets, STATUS bit indices, TX/RX state encodings.
REQ-031 One sub-module uart_rx_fifo (sync FIFO, push/pop/full/empty), instantiated only under the macro.

Verification
REQ-032 DIVISOR=3, write DATA 0xA5 -> uart_tx: 0, 1,0,1,0,0,1,0,1, 1, each bit 4 clocks; tx_busy high 40 clocks.
REQ-033 Loop uart_tx to uart_rx, send 0x3C -> rx_valid=1, irq_o=1, DATA read returns 0x3C, then rx_valid=0.
REQ-034 Drive 0x55 with stop bit 0 -> rx_frame_err=1, rx_valid=0; write 0x8 to STATUS clears it.
REQ-035 FIFO enabled, RX_DEPTH=4, send 5 bytes unread -> rx_overrun=1, reads return first 4 bytes in order.
REQ-036 Read 0xC -> wb_err_o one cycle, wb_ack_o 0; 2-clock low glitch on uart_rx at DIVISOR=7 -> no byte received.
REQ-037 Assert nrst_i mid-TX frame -> uart_tx=1 immediately, tx_busy=0, DIVISOR reads 433.
